// File: rtl/noc_input_port.sv
// -----------------------------------------------------------------------------
// noc_input_port
//
// Per-port input stage of the NoC router. Incoming flits are buffered in a
// small FIFO. The destination of the head flit at the FIFO front goes to the
// YX route processor, and the direction it returns is latched. That output is
// then requested from the switch allocator. After the grant, the packet's
// flits are streamed to the crossbar up to and including the tail, and the
// request is released.
//
// Ports:
//   clk_i            - clock, rising edge
//   rst_n_i          - asynchronous active-low reset
//   in_flit_i        - flit from the upstream link
//   in_valid_i       - in_flit_i is valid
//   in_ready_o       - FIFO can accept a flit (count < DEPTH)
//   yx_addr_header_o - destination bits [7:0] of the FIFO front (0 when empty)
//   yx_dir_i         - direction from the route processor (0..4 valid)
//   req_o            - one-hot allocator request, [0]N [1]S [2]W [3]E [4]L
//   gnt_i            - allocator grant, held while req_o is asserted
//   out_flit_o       - FIFO front entry to the crossbar
//   out_valid_o      - out_flit_o is valid
//   out_ready_i      - crossbar accepts the flit
//   err_o            - sticky protocol error, cleared only by reset
//
// Flit type field [FLIT_W-1:FLIT_W-2]: 01 head, 00 body, 10 tail, 11 single.
// Bit 0 of the type marks a head and bit 1 marks a tail.
// -----------------------------------------------------------------------------
module noc_input_port #(
    parameter int DEPTH  = 4,
    parameter int FLIT_W = 34
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [FLIT_W-1:0] in_flit_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [7:0]        yx_addr_header_o,
    input  logic [2:0]        yx_dir_i,
    output logic [4:0]        req_o,
    input  logic              gnt_i,
    output logic [FLIT_W-1:0] out_flit_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              err_o
);

    localparam int         AW          = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C    = (AW + 1)'(DEPTH);
    localparam logic [1:0] TYPE_HEAD   = 2'b01;
    localparam logic [1:0] TYPE_TAIL   = 2'b10;
    localparam logic [1:0] TYPE_SINGLE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_ACTIVE,
        S_DROP
    } state_t;

    // FIFO storage and bookkeeping
    logic [FLIT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;

    // Control state
    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_dir;
    logic [2:0]        w_dir_nxt;
    logic              r_err;
    logic              w_err_nxt;
    // Set once the current packet has forwarded its first flit. This tells
    // the packet's own head apart from a stray head that arrives mid-packet.
    logic              r_mid;
    logic              w_mid_nxt;

    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic [FLIT_W-1:0] w_front;
    logic [1:0]        w_front_type;
    logic              w_dir_valid;

    assign w_empty          = (r_count == '0);
    assign w_front          = r_mem[r_rd_ptr];
    assign w_front_type     = w_front[FLIT_W-1 -: 2];
    assign w_dir_valid      = (yx_dir_i <= 3'd4);

    // Ready depends only on the registered count: a full FIFO does not
    // accept a flit even in a cycle where it pops one.
    assign in_ready_o       = (r_count < DEPTH_C);
    assign w_push           = in_valid_i & in_ready_o;

    assign out_flit_o       = w_front;
    assign yx_addr_header_o = w_empty ? 8'h00 : w_front[7:0];
    assign err_o            = r_err;

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch is inferred.
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_err_nxt   = r_err;
        w_mid_nxt   = r_mid;
        w_pop       = 1'b0;
        out_valid_o = 1'b0;
        req_o       = '0;

        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    if (w_front_type[0]) begin
                        // Head or single at the front. The route processor
                        // answers combinationally in this same cycle.
                        w_dir_nxt = yx_dir_i;
                        if (w_dir_valid) begin
                            w_state_nxt = S_REQ;
                        end else begin
                            w_err_nxt = 1'b1;
                            if (w_front_type == TYPE_SINGLE) begin
                                w_pop = 1'b1;
                            end else begin
                                w_state_nxt = S_DROP;
                            end
                        end
                    end else begin
                        // Body or tail with no head before it: discard.
                        w_pop     = 1'b1;
                        w_err_nxt = 1'b1;
                    end
                end
            end

            S_REQ: begin
                req_o = 5'b00001 << r_dir;
                if (gnt_i) begin
                    w_state_nxt = S_ACTIVE;
                    w_mid_nxt   = 1'b0;
                end
            end

            S_ACTIVE: begin
                req_o       = 5'b00001 << r_dir;
                out_valid_o = gnt_i & ~w_empty;
                w_pop       = out_valid_o & out_ready_i;
                if (!gnt_i) begin
                    w_err_nxt = 1'b1;
                end
                if (w_pop) begin
                    w_mid_nxt = 1'b1;
                    if (w_front_type == TYPE_HEAD && r_mid) begin
                        w_err_nxt = 1'b1;
                    end
                    if (w_front_type[1]) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            S_DROP: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_front_type == TYPE_TAIL) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control state registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_dir   <= '0;
            r_err   <= 1'b0;
            r_mid   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_err   <= w_err_nxt;
            r_mid   <= w_mid_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FIFO
    // -------------------------------------------------------------------------
    // NOTE: the storage is reset on purpose, because out_flit_o must read zero after reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_flit_i;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_input_port.sv
// -----------------------------------------------------------------------------
// tb_noc_input_port
//
// Self-checking bench for noc_input_port. A behavioural model keeps the port's
// contents as a queue of flits plus a packet phase. The model compares every
// DUT output on each falling edge. Directed scenarios add hand-computed
// expectations, and a randomized packet stream follows them. The bench
// itself acts as the route processor (direction = dest[2:0]), the upstream
// link, the allocator and the crossbar.
// -----------------------------------------------------------------------------
module tb_noc_input_port;

    localparam int         DEPTH    = 4;
    localparam int         FW       = 34;
    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    // Model packet phases
    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;  // direction known, waiting for grant
    localparam int M_FWD  = 2;  // granted, forwarding flits
    localparam int M_DISC = 3;  // discarding a badly routed packet

    logic          clk_i;
    logic          rst_n_i;
    logic [FW-1:0] in_flit_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [7:0]    yx_addr_header_o;
    logic [2:0]    yx_dir_i;
    logic [4:0]    req_o;
    logic          gnt_i;
    logic [FW-1:0] out_flit_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic          err_o;

    noc_input_port #(.DEPTH(DEPTH), .FLIT_W(FW)) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .in_flit_i        (in_flit_i),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .yx_addr_header_o (yx_addr_header_o),
        .yx_dir_i         (yx_dir_i),
        .req_o            (req_o),
        .gnt_i            (gnt_i),
        .out_flit_o       (out_flit_o),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .err_o            (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Stand-in route processor: direction is the low three destination bits,
    // so 5, 6 and 7 are invalid directions.
    function automatic logic [2:0] route(input logic [7:0] dest);
        return dest[2:0];
    endfunction

    assign yx_dir_i = route(yx_addr_header_o);

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [7:0] dest, input int seq);
        return {t, 24'(seq), dest};
    endfunction

    // ---------------------------------------------------------------- checks
    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ----------------------------------------------------------------- model
    logic [FW-1:0] mq[$];
    int            m_mode;
    logic [2:0]    m_dir;
    bit            m_err;
    int            m_fwd_cnt;

    task automatic model_reset();
        mq.delete();
        m_mode    = M_IDLE;
        m_dir     = 3'd0;
        m_err     = 1'b0;
        m_fwd_cnt = 0;
    endtask

    task automatic model_step();
        logic [7:0] e_addr;
        logic [4:0] e_req;
        logic       e_ov;
        logic [1:0] ft;
        bit         pop;
        bit         push;

        e_addr = (mq.size() == 0) ? 8'h00 : mq[0][7:0];
        e_req  = (m_mode == M_WAIT || m_mode == M_FWD) ? 5'(1 << m_dir) : 5'b0;
        e_ov   = (m_mode == M_FWD) && gnt_i && (mq.size() > 0);

        check("in_ready",  64'(in_ready_o),       64'(mq.size() < DEPTH));
        check("addr",      64'(yx_addr_header_o), 64'(e_addr));
        check("req",       64'(req_o),            64'(e_req));
        check("out_valid", 64'(out_valid_o),      64'(e_ov));
        check("err",       64'(err_o),            64'(m_err));
        if (e_ov) check("out_flit", 64'(out_flit_o), 64'(mq[0]));

        pop = 1'b0;
        ft  = (mq.size() > 0) ? mq[0][FW-1 -: 2] : T_BODY;
        case (m_mode)
            M_IDLE: if (mq.size() > 0) begin
                if (ft == T_HEAD || ft == T_SINGLE) begin
                    if (route(mq[0][7:0]) <= 3'd4) begin
                        m_dir  = route(mq[0][7:0]);
                        m_mode = M_WAIT;
                    end else begin
                        m_err = 1'b1;
                        if (ft == T_SINGLE) pop = 1'b1;
                        else m_mode = M_DISC;
                    end
                end else begin
                    pop   = 1'b1;
                    m_err = 1'b1;
                end
            end
            M_WAIT: if (gnt_i) begin
                m_mode    = M_FWD;
                m_fwd_cnt = 0;
            end
            M_FWD: begin
                if (!gnt_i) m_err = 1'b1;
                if (e_ov && out_ready_i) begin
                    pop = 1'b1;
                    if (ft == T_HEAD && m_fwd_cnt > 0) m_err = 1'b1;
                    m_fwd_cnt++;
                    if (ft == T_TAIL || ft == T_SINGLE) m_mode = M_IDLE;
                end
            end
            default: if (mq.size() > 0) begin
                pop = 1'b1;
                if (ft == T_TAIL) m_mode = M_IDLE;
            end
        endcase

        push = in_valid_i && (mq.size() < DEPTH);
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(in_flit_i);
    endtask

    // Compare process: outputs are stable at the falling edge.
    int rst_cnt  = 0;
    int rst_seen = 0;
    bit chk_en   = 1'b0;
    int dut_xfer = 0;
    int dut_push = 0;

    always @(negedge clk_i) begin
        if (rst_seen != rst_cnt) begin
            rst_seen = rst_cnt;
            model_reset();
        end
        if (chk_en && rst_n_i) begin
            if (out_valid_o && out_ready_i) dut_xfer++;
            if (in_valid_i && in_ready_o)   dut_push++;
            model_step();
        end
    end

    // -------------------------------------------------------------- stimulus
    logic [FW-1:0] tx_q[$];
    int valid_pct  = 100;
    int ready_mode = 0;    // 0 always ready, 1 toggle, 2 random
    int gnt_pct    = 100;
    bit gnt_block  = 1'b0;
    bit gnt_glitch = 1'b0;
    int seq_n      = 1;

    // One clock: retire the flit accepted at the coming edge, then drive the
    // next cycle's inputs 1 time unit after the edge.
    task automatic cycle();
        if (in_valid_i && in_ready_o) void'(tx_q.pop_front());
        @(posedge clk_i);
        #1;
        if (tx_q.size() > 0 && $urandom_range(99) < valid_pct) begin
            in_valid_i = 1'b1;
            in_flit_i  = tx_q[0];
        end else begin
            in_valid_i = 1'b0;
            in_flit_i  = FW'({$urandom(), $urandom()});
        end
        case (ready_mode)
            0:       out_ready_i = 1'b1;
            1:       out_ready_i = ~out_ready_i;
            default: out_ready_i = ($urandom_range(99) < 70);
        endcase
        if (req_o == 5'b0 || gnt_block)                gnt_i = 1'b0;
        else if (!gnt_i)                               gnt_i = ($urandom_range(99) < gnt_pct);
        else if (gnt_glitch && $urandom_range(63) == 0) gnt_i = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #2;
        rst_n_i    = 1'b0;
        rst_cnt++;
        in_valid_i = 1'b0;
        gnt_i      = 1'b0;
        tx_q.delete();
        #1;
        check("rst_req",       64'(req_o),            64'(0));
        check("rst_out_valid", 64'(out_valid_o),      64'(0));
        check("rst_err",       64'(err_o),            64'(0));
        check("rst_in_ready",  64'(in_ready_o),       64'(1));
        check("rst_addr",      64'(yx_addr_header_o), 64'(0));
        check("rst_out_flit",  64'(out_flit_o),       64'(0));
        #1;
        rst_n_i = 1'b1;
        chk_en  = 1'b1;
    endtask

    task automatic gen_random(input int npkt);
        int         len;
        int         r;
        logic [2:0] d;
        logic [7:0] dest;
        for (int p = 0; p < npkt; p++) begin
            len  = $urandom_range(1, 5);
            r    = $urandom_range(99);
            d    = (r < 10) ? 3'(5 + $urandom_range(2)) : 3'($urandom_range(4));
            dest = {4'($urandom_range(15)), 1'($urandom_range(1)), d};
            if (r >= 95) tx_q.push_back(mk(T_BODY, 8'hA5, seq_n++));
            if (len == 1) begin
                tx_q.push_back(mk(T_SINGLE, dest, seq_n++));
            end else begin
                tx_q.push_back(mk(T_HEAD, dest, seq_n++));
                for (int k = 1; k < len - 1; k++) begin
                    if (r >= 90 && r < 95 && k == 1) tx_q.push_back(mk(T_HEAD, 8'hA5, seq_n++));
                    else                             tx_q.push_back(mk(T_BODY, 8'hA5, seq_n++));
                end
                tx_q.push_back(mk(T_TAIL, 8'hA5, seq_n++));
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        logic [FW-1:0] f;
        int            x0;
        int            p0;
        int            budget;

        rst_n_i     = 1'b0;
        in_flit_i   = '0;
        in_valid_i  = 1'b0;
        gnt_i       = 1'b0;
        out_ready_i = 1'b1;

        // 1) Single flit to E: REQ two cycles after the push cycle, transfer on the third.
        do_reset();
        f = mk(T_SINGLE, 8'h23, seq_n++);
        tx_q.push_back(f);
        cycle();                                                    // cycle t: flit offered
        cycle();                                                    // t+1: IDLE, front visible
        check("t1_idle_req", 64'(req_o), 64'(0));
        cycle();                                                    // t+2: REQ
        check("t1_req",      64'(req_o),       64'(5'b01000));
        check("t1_no_out",   64'(out_valid_o), 64'(0));
        cycle();                                                    // t+3: transfer
        check("t1_valid",    64'(out_valid_o), 64'(1));
        check("t1_flit",     64'(out_flit_o),  64'(f));
        cycle();                                                    // t+4: released
        check("t1_req_drop", 64'(req_o), 64'(0));

        // 2) Four-flit packet to Local with out_ready toggling.
        do_reset();
        ready_mode = 1;
        x0 = dut_xfer;
        tx_q.push_back(mk(T_HEAD, 8'h14, seq_n++));
        tx_q.push_back(mk(T_BODY, 8'hA5, seq_n++));
        tx_q.push_back(mk(T_BODY, 8'hA5, seq_n++));
        tx_q.push_back(mk(T_TAIL, 8'hA5, seq_n++));
        budget = 0;
        while (req_o == 5'b0 && budget < 20) begin cycle(); budget++; end
        check("t2_req", 64'(req_o), 64'(5'b10000));
        run(25);
        check("t2_xfers",   64'(dut_xfer - x0), 64'(4));
        check("t2_req_end", 64'(req_o),         64'(0));

        // 3) DEPTH+2 flits with the grant withheld, then drain.
        do_reset();
        ready_mode = 0;
        gnt_block  = 1'b1;
        x0 = dut_xfer;
        p0 = dut_push;
        tx_q.push_back(mk(T_HEAD, 8'h23, seq_n++));
        for (int i = 0; i < DEPTH; i++) tx_q.push_back(mk(T_BODY, 8'hA5, seq_n++));
        tx_q.push_back(mk(T_TAIL, 8'hA5, seq_n++));
        run(10);
        check("t3_full",   64'(in_ready_o),     64'(0));
        check("t3_pushes", 64'(dut_push - p0),  64'(DEPTH));
        gnt_block = 1'b0;
        run(30);
        check("t3_xfers",  64'(dut_xfer - x0),  64'(DEPTH + 2));
        check("t3_ready",  64'(in_ready_o),     64'(1));
        check("t3_empty",  64'(yx_addr_header_o), 64'(0));

        // 4) Invalid direction drops the whole packet, then a good one routes.
        do_reset();
        x0 = dut_xfer;
        tx_q.push_back(mk(T_HEAD, 8'h17, seq_n++));
        tx_q.push_back(mk(T_BODY, 8'hA5, seq_n++));
        tx_q.push_back(mk(T_TAIL, 8'hA5, seq_n++));
        run(20);
        check("t4_err",    64'(err_o),            64'(1));
        check("t4_xfers",  64'(dut_xfer - x0),    64'(0));
        check("t4_empty",  64'(yx_addr_header_o), 64'(0));
        tx_q.push_back(mk(T_HEAD, 8'h22, seq_n++));
        tx_q.push_back(mk(T_TAIL, 8'hA5, seq_n++));
        run(20);
        check("t4_next_xfers", 64'(dut_xfer - x0), 64'(2));
        check("t4_next_req",   64'(req_o),         64'(0));

        // 5) Orphan body into an empty port.
        do_reset();
        tx_q.push_back(mk(T_BODY, 8'h5A, seq_n++));
        cycle();
        cycle();
        cycle();
        check("t5_err",   64'(err_o),            64'(1));
        check("t5_req",   64'(req_o),            64'(0));
        check("t5_empty", 64'(yx_addr_header_o), 64'(0));

        // 6) Reset mid-packet; the rest of the old packet arrives as orphans.
        do_reset();
        x0 = dut_xfer;
        tx_q.push_back(mk(T_HEAD, 8'h23, seq_n++));
        tx_q.push_back(mk(T_BODY, 8'hA5, seq_n++));
        budget = 0;
        while (dut_xfer - x0 < 2 && budget < 20) begin cycle(); budget++; end
        check("t6_fwd",    64'(dut_xfer - x0), 64'(2));
        check("t6_active", 64'(req_o),         64'(5'b01000));
        do_reset();
        x0 = dut_xfer;
        tx_q.push_back(mk(T_BODY, 8'hA5, seq_n++));
        tx_q.push_back(mk(T_TAIL, 8'hA5, seq_n++));
        run(10);
        check("t6_err",   64'(err_o),            64'(1));
        check("t6_xfers", 64'(dut_xfer - x0),    64'(0));
        check("t6_req",   64'(req_o),            64'(0));
        check("t6_empty", 64'(yx_addr_header_o), 64'(0));

        // 7) Randomized traffic against the model.
        do_reset();
        valid_pct  = 70;
        ready_mode = 2;
        gnt_pct    = 50;
        gnt_glitch = 1'b1;
        gen_random(60);
        budget = 0;
        while (tx_q.size() > 0 && budget < 4000) begin cycle(); budget++; end
        check("rand_sent", 64'(tx_q.size()), 64'(0));
        ready_mode = 0;
        gnt_pct    = 100;
        gnt_glitch = 1'b0;
        run(60);
        check("rand_ready", 64'(in_ready_o),       64'(1));
        check("rand_empty", 64'(yx_addr_header_o), 64'(0));
        check("rand_req",   64'(req_o),            64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
